// File: rtl/allocate_frcr_timer_pkg.sv
// Shared width defaults and reset constants for the allocate-stage free-running timer.
package allocate_frcr_timer_pkg;

    localparam int ALLOCATE_FRCR_WIDTH      = 64;
    localparam int ALLOCATE_FRCR_PRESCALE_W = 8;
    localparam int ALLOCATE_FRCR_MAX_W      = 128;

    // Compare registers come out of reset parked at all-ones; callers truncate to their width.
    function automatic logic [ALLOCATE_FRCR_MAX_W-1:0] cmp_reset_val();
        return '1;
    endfunction

endpackage

// File: rtl/allocate_frcr_timer_cmp_ch.sv
// One compare channel: compare register plus sticky match flag.
// Flag sets on the edge that lands the matching count; set beats a same-cycle ack.
module allocate_frcr_timer_cmp_ch
    import allocate_frcr_timer_pkg::*;
#(
    parameter int P_WIDTH = ALLOCATE_FRCR_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_clr_i,
    input  logic               inc_i,
    input  logic [P_WIDTH-1:0] next_cnt_i,
    input  logic               wr_i,
    input  logic [P_WIDTH-1:0] wr_data_i,
    input  logic               ena_i,
    input  logic               ack_i,
    output logic               irq_o
);

    logic [P_WIDTH-1:0] cmp_q, cmp_d;
    logic               irq_q, irq_d;
    logic               match;

    always_comb begin
        // Match uses the register value from before any write on this edge.
        match = inc_i && ena_i && (next_cnt_i == cmp_q);
        cmp_d = wr_i ? wr_data_i : cmp_q;
        irq_d = irq_q;
        if (sync_clr_i)  irq_d = 1'b0;
        else if (match)  irq_d = 1'b1;
        else if (ack_i)  irq_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= P_WIDTH'(cmp_reset_val());
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/allocate_frcr_timer_cmp.sv
// Free-running counter with prescaler, per-channel compare IRQs, sticky wrap flag and snapshot.
// Priority each cycle: sync clear > software load > prescaled tick > hold.
module allocate_frcr_timer_cmp
    import allocate_frcr_timer_pkg::*;
#(
    parameter int P_WIDTH      = ALLOCATE_FRCR_WIDTH,
    parameter int P_CMP_NUM    = 2,
    parameter int P_PRESCALE_W = ALLOCATE_FRCR_PRESCALE_W
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    input  logic                    iRESET_SYNC,
    input  logic                    iENA,
    input  logic [P_PRESCALE_W-1:0] iPRESCALE,
    input  logic                    iWR_ENA,
    input  logic [P_WIDTH-1:0]      iWR_DATA,
    input  logic [P_CMP_NUM-1:0]    iCMP_WR_ENA,
    input  logic [P_WIDTH-1:0]      iCMP_WR_DATA,
    input  logic [P_CMP_NUM-1:0]    iCMP_ENA,
    input  logic [P_CMP_NUM-1:0]    iCMP_IRQ_ACK,
    input  logic                    iSNAP_REQ,
    output logic [P_WIDTH-1:0]      oCOUNTER,
    output logic [P_WIDTH-1:0]      oSNAP_COUNTER,
    output logic                    oTICK,
    output logic                    oWRAP,
    output logic [P_CMP_NUM-1:0]    oCMP_IRQ
);

    logic [P_WIDTH-1:0]      counter_q, counter_d;
    logic [P_WIDTH-1:0]      snap_q, snap_d;
    logic [P_PRESCALE_W-1:0] presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic                    wrap_q, wrap_d;
    logic                    tick, inc;

    always_comb begin
        // Equality (not >=) so a lowered divide value lets presc run on to its natural wrap.
        tick      = iENA && (presc_q == iPRESCALE);
        inc       = tick && !iRESET_SYNC && !iWR_ENA;
        counter_d = counter_q;
        presc_d   = presc_q;
        wrap_d    = wrap_q;
        if (iRESET_SYNC) begin
            counter_d = '0;
            presc_d   = '0;
            wrap_d    = 1'b0;
        end else if (iWR_ENA) begin
            counter_d = iWR_DATA;
            presc_d   = '0;
            wrap_d    = 1'b0;
        end else if (iENA) begin
            if (tick) begin
                counter_d = counter_q + P_WIDTH'(1);
                presc_d   = '0;
                if (counter_q == '1) wrap_d = 1'b1;
            end else begin
                presc_d = presc_q + P_PRESCALE_W'(1);
            end
        end
        tick_d = inc;
        if (iRESET_SYNC)    snap_d = '0;
        else if (iSNAP_REQ) snap_d = counter_d;
        else                snap_d = snap_q;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            counter_q <= '0;
            snap_q    <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            snap_q    <= snap_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    for (genvar i = 0; i < P_CMP_NUM; i++) begin : g_ch
        allocate_frcr_timer_cmp_ch #(
            .P_WIDTH (P_WIDTH)
        ) u_ch (
            .clk        (iCLOCK),
            .rst_n      (inRESET),
            .sync_clr_i (iRESET_SYNC),
            .inc_i      (inc),
            .next_cnt_i (counter_d),
            .wr_i       (iCMP_WR_ENA[i]),
            .wr_data_i  (iCMP_WR_DATA),
            .ena_i      (iCMP_ENA[i]),
            .ack_i      (iCMP_IRQ_ACK[i]),
            .irq_o      (oCMP_IRQ[i])
        );
    end

    assign oCOUNTER      = counter_q;
    assign oSNAP_COUNTER = snap_q;
    assign oTICK         = tick_q;
    assign oWRAP         = wrap_q;

endmodule

// File: doc/allocate_frcr_timer_cmp.md
Name: allocate_frcr_timer_cmp

Overview:
Parametrised free-running counter with a programmable prescaler, P_CMP_NUM compare channels and sticky per-channel interrupt flags. It is the next-generation system timer in the allocate stage. It keeps the existing sync-clear and software-load semantics, and adds tick division, compare-match IRQs, a wrap flag and an atomic snapshot for narrow-bus readers.

Parameters:
P_WIDTH, 64, counter and compare register width
P_CMP_NUM, 2, number of compare channels (1..8)
P_PRESCALE_W, 8, prescaler divide-value width

Ports:
iCLOCK  in  1  system clock
inRESET  in  1  asynchronous, active-low reset
iRESET_SYNC  in  1  synchronous clear of counter, prescaler, flags
iENA  in  1  count enable; when low, prescaler and counter hold
iPRESCALE  in  P_PRESCALE_W  tick every iPRESCALE+1 enabled cycles
iWR_ENA  in  1  load counter
iWR_DATA  in  P_WIDTH  counter load value
iCMP_WR_ENA  in  P_CMP_NUM  per-channel compare register write strobe
iCMP_WR_DATA  in  P_WIDTH  shared compare write data
iCMP_ENA  in  P_CMP_NUM  per-channel match enable
iCMP_IRQ_ACK  in  P_CMP_NUM  per-channel IRQ clear
iSNAP_REQ  in  1  capture counter into snapshot register
oCOUNTER  out  P_WIDTH  live counter
oSNAP_COUNTER  out  P_WIDTH  snapshot value
oTICK  out  1  registered pulse, high the cycle after each counter increment
oWRAP  out  1  sticky, set when counter wraps all-ones -> 0
oCMP_IRQ  out  P_CMP_NUM  sticky match flags

Behaviour:
- Reset (async, inRESET=0): counter=0, prescaler=0, snapshot=0, compare regs=all-ones, oTICK=0, oWRAP=0, oCMP_IRQ=0.
- Prescaler: while iENA=1, presc increments. When presc==iPRESCALE, a tick occurs and presc returns to 0. iPRESCALE=0 gives a tick every cycle. If iPRESCALE is lowered below the current presc, the next tick occurs after presc wraps at 2^P_PRESCALE_W-1.
- Counter priority per cycle: iRESET_SYNC > iWR_ENA > tick increment > hold.
- iRESET_SYNC clears counter, presc, snapshot, oWRAP and oCMP_IRQ. It does not clear compare regs.
- iWR_ENA loads iWR_DATA and clears presc. Loading never raises a match or wrap.
- Increment is modulo 2^P_WIDTH. On increment from all-ones, counter becomes 0 and oWRAP sets (sticky). oWRAP clears only on iRESET_SYNC or iWR_ENA.
- oTICK is registered and high exactly one cycle after each increment.
- Compare write: compare reg i <= iCMP_WR_DATA when iCMP_WR_ENA[i]. Multiple channels may be written in the same cycle.
- Match[i]: true in a cycle where an increment occurs, iCMP_ENA[i]=1, and the incremented value == compare reg i. The compare reg value used is the one before any same-cycle write.
- oCMP_IRQ[i] sets on the clock edge ending the match cycle, so it is visible together with the matched counter value (latency 0 relative to oCOUNTER).
- oCMP_IRQ[i] clears on iCMP_IRQ_ACK[i]. If set and ack occur in the same cycle, set wins.
- Snapshot: iSNAP_REQ loads oSNAP_COUNTER with the post-update counter value of the same edge, i.e. it equals oCOUNTER in the following cycle. Not affected by iWR_ENA.
- iENA=0: no ticks and no matches; writes, acks and sync clear still act.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending match or tick is discarded.

Decomposition:
- Package allocate_frcr_timer_pkg: default width constants (ALLOCATE_FRCR_WIDTH=64, ALLOCATE_FRCR_PRESCALE_W=8) and the compare-register reset value function (all-ones).
- Sub-module allocate_frcr_timer_cmp_ch: one compare register plus sticky IRQ flag. Instantiated P_CMP_NUM times via generate. Inputs: next-count, increment strobe, write, enable, ack.

Test Plan:
- Reset, iENA=1, iPRESCALE=0, 5 cycles -> oCOUNTER=5; oTICK high every cycle from cycle 2.
- iPRESCALE=3, iENA=1, 12 cycles -> oCOUNTER=3; oTICK pulses 4 cycles apart.
- iWR_DATA=all-ones with iWR_ENA, then one tick -> oCOUNTER=0, oWRAP=1, no oCMP_IRQ (compare regs at reset value all-ones).
- cmp0=10, cmp1=12, both enabled, count from 0 -> oCMP_IRQ=01 when oCOUNTER=10, 11 when oCOUNTER=12. Ack ch0 in the same cycle as ch1 match -> oCMP_IRQ=10. Ack and set on the same channel in the same cycle -> flag stays 1.
- iWR_ENA load 10 with cmp0=10 -> no IRQ. iCMP_ENA=0 while passing through match value -> no IRQ. iENA=0 -> counter frozen, then iRESET_SYNC -> counter, oWRAP and oCMP_IRQ all 0.
- iSNAP_REQ at oCOUNTER=0x1234 with ongoing ticks -> oSNAP_COUNTER=0x1235 and stays there as oCOUNTER continues counting. Assert inRESET mid-count -> all outputs return to reset values asynchronously.
